// File: rtl/bomb_ctrl_if.sv
// rtl/bomb_ctrl_if.sv - player/bomb controller signal bundle
// Purpose: groups the player-side request/position inputs and the bomb/blast
//          outputs of bomb_ctrl into one interface.
// Signals:
//   allow        game-state code (freeze codes 00000, 00001, 11111)
//   bomb_drop    drop request level
//   userX/userY  player top-left position
//   bomb_active, bombX, bombY             armed bomb status and tile origin
//   blast_active, blastH*, blastV*        blast arm rectangles
// Modports: master = player side, slave = bomb_ctrl.
interface bomb_ctrl_if;
  logic [4:0] allow;
  logic       bomb_drop;
  logic [9:0] userX;
  logic [9:0] userY;
  logic       bomb_active;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic       blast_active;
  logic [9:0] blastHX;
  logic [9:0] blastHY;
  logic [9:0] blastHXS;
  logic [9:0] blastHYS;
  logic [9:0] blastVX;
  logic [9:0] blastVY;
  logic [9:0] blastVXS;
  logic [9:0] blastVYS;

  modport master (
    output allow, bomb_drop, userX, userY,
    input  bomb_active, bombX, bombY, blast_active,
    input  blastHX, blastHY, blastHXS, blastHYS,
    input  blastVX, blastVY, blastVXS, blastVYS
  );

  modport slave (
    input  allow, bomb_drop, userX, userY,
    output bomb_active, bombX, bombY, blast_active,
    output blastHX, blastHY, blastHXS, blastHYS,
    output blastVX, blastVY, blastVXS, blastVYS
  );
endinterface

// File: rtl/bomb_ctrl.sv
// rtl/bomb_ctrl.sv - single-player bomb lifecycle controller
// Purpose: snaps a dropped bomb to the 32-px tile grid, runs the fuse, then
//          drives cross-shaped blast rectangles for BLAST_FRAMES frames.
// Ports:
//   frame_clk  frame clock (only clock)
//   Reset      synchronous active-high reset
//   bus        bomb_ctrl_if.slave (allow, bomb_drop, userX/userY in;
//              bomb/blast status and rectangles out)
// Parameters: FUSE_FRAMES, BLAST_FRAMES, RANGE (arm length in tiles).
// Optional feature macro: BOMB_REMOTE_DET_EN - a second drop edge while armed
//   detonates the bomb early.
module bomb_ctrl #(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int RANGE        = 2
) (
  input logic       frame_clk,
  input logic       Reset,
  bomb_ctrl_if.slave bus
);

  localparam logic [15:0] FUSE_LOAD  = 16'(FUSE_FRAMES - 1);
  localparam logic [15:0] BLAST_LOAD = 16'(BLAST_FRAMES - 1);
  localparam logic [11:0] ARM_LEN    = 12'(RANGE * 32);

  typedef enum logic [1:0] {IDLE, ARMED, BLAST} state_t;

  state_t      state_q;
  logic        drop_q;
  logic [15:0] fuse_cnt_q;
  logic [15:0] blast_cnt_q;
  logic        bomb_active_q;
  logic        blast_active_q;
  logic [9:0]  bombX_q, bombY_q;
  logic [9:0]  blastHX_q, blastHY_q, blastHXS_q, blastHYS_q;
  logic [9:0]  blastVX_q, blastVY_q, blastVXS_q, blastVYS_q;

  logic        run_d;
  logic        edge_d;
  logic [9:0]  tx_raw_d, ty_raw_d;
  logic [9:0]  tx_d, ty_d;
  logic [11:0] bx_d, by_d;
  logic [11:0] hx_d, vy_d;
  logic [11:0] hend_d, vend_d;

  always_comb begin
    run_d  = !(bus.allow inside {5'b00000, 5'b00001, 5'b11111});
    edge_d = bus.bomb_drop & ~drop_q;

    // Sprite centre (18x26) rounded down to the tile, kept inside the arena.
    tx_raw_d = (bus.userX + 10'd9) & 10'h3E0;
    ty_raw_d = (bus.userY + 10'd13) & 10'h3E0;
    tx_d = (tx_raw_d < 10'd32) ? 10'd32 : (tx_raw_d > 10'd576) ? 10'd576 : tx_raw_d;
    ty_d = (ty_raw_d < 10'd32) ? 10'd32 : (ty_raw_d > 10'd416) ? 10'd416 : ty_raw_d;

    // Arm extents from the latched tile; 12-bit math so neither the start
    // can wrap below zero nor the end overflow before clamping.
    bx_d   = {2'b00, bombX_q};
    by_d   = {2'b00, bombY_q};
    hx_d   = (bx_d >= 12'd32 + ARM_LEN) ? bx_d - ARM_LEN : 12'd32;
    vy_d   = (by_d >= 12'd32 + ARM_LEN) ? by_d - ARM_LEN : 12'd32;
    hend_d = (bx_d + ARM_LEN + 12'd32 < 12'd608) ? bx_d + ARM_LEN + 12'd32 : 12'd608;
    vend_d = (by_d + ARM_LEN + 12'd32 < 12'd448) ? by_d + ARM_LEN + 12'd32 : 12'd448;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      drop_q         <= 1'b0;
      fuse_cnt_q     <= '0;
      blast_cnt_q    <= '0;
      bomb_active_q  <= 1'b0;
      blast_active_q <= 1'b0;
      bombX_q        <= '0;
      bombY_q        <= '0;
      blastHX_q      <= '0;
      blastHY_q      <= '0;
      blastHXS_q     <= '0;
      blastHYS_q     <= '0;
      blastVX_q      <= '0;
      blastVY_q      <= '0;
      blastVXS_q     <= '0;
      blastVYS_q     <= '0;
    end else begin
      // Sampled even while frozen so a key held across a freeze never
      // produces a late edge.
      drop_q <= bus.bomb_drop;
      if (run_d) begin
        case (state_q)
          IDLE: begin
            if (edge_d) begin
              bombX_q       <= tx_d;
              bombY_q       <= ty_d;
              fuse_cnt_q    <= FUSE_LOAD;
              bomb_active_q <= 1'b1;
              state_q       <= ARMED;
            end
          end
          ARMED: begin
            if (fuse_cnt_q == 16'd0) begin
              state_q        <= BLAST;
              bomb_active_q  <= 1'b0;
              blast_active_q <= 1'b1;
              blast_cnt_q    <= BLAST_LOAD;
              blastHX_q      <= hx_d[9:0];
              blastHY_q      <= bombY_q;
              blastHXS_q     <= 10'(hend_d - hx_d);
              blastHYS_q     <= 10'd32;
              blastVX_q      <= bombX_q;
              blastVY_q      <= vy_d[9:0];
              blastVXS_q     <= 10'd32;
              blastVYS_q     <= 10'(vend_d - vy_d);
            end else begin
`ifdef BOMB_REMOTE_DET_EN
              fuse_cnt_q <= edge_d ? 16'd0 : fuse_cnt_q - 16'd1;
`else
              fuse_cnt_q <= fuse_cnt_q - 16'd1;
`endif
            end
          end
          BLAST: begin
            if (blast_cnt_q == 16'd0) begin
              state_q        <= IDLE;
              blast_active_q <= 1'b0;
              blastHX_q      <= '0;
              blastHY_q      <= '0;
              blastHXS_q     <= '0;
              blastHYS_q     <= '0;
              blastVX_q      <= '0;
              blastVY_q      <= '0;
              blastVXS_q     <= '0;
              blastVYS_q     <= '0;
            end else begin
              blast_cnt_q <= blast_cnt_q - 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.bomb_active  = bomb_active_q;
  assign bus.bombX        = bombX_q;
  assign bus.bombY        = bombY_q;
  assign bus.blast_active = blast_active_q;
  assign bus.blastHX      = blastHX_q;
  assign bus.blastHY      = blastHY_q;
  assign bus.blastHXS     = blastHXS_q;
  assign bus.blastHYS     = blastHYS_q;
  assign bus.blastVX      = blastVX_q;
  assign bus.blastVY      = blastVY_q;
  assign bus.blastVXS     = blastVXS_q;
  assign bus.blastVYS     = blastVYS_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb/tb_bomb_ctrl.sv - directed self-checking bench for bomb_ctrl
module tb_bomb_ctrl;

  logic frame_clk;
  logic Reset;
  bomb_ctrl_if bus ();

  bomb_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int arm_n, blast_n;
  logic [9:0] b_x, b_y;
  logic [9:0] h_x, h_y, h_xs, h_ys, v_x, v_y, v_xs, v_ys;
  logic entry_blast, entry_bomb;
  logic post_active, post_blast;
  logic [9:0] post_hx, post_vys, post_bx;

`ifdef BOMB_REMOTE_DET_EN
  localparam int REMOTE_ARM = 41;
`else
  localparam int REMOTE_ARM = 120;
`endif

  task automatic step(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One full bomb lifecycle. frz_at/frz_len freeze allow for frz_len cycles
  // starting at armed cycle frz_at; edge_at/bedge_at pulse a second drop at
  // that armed/blast cycle index (-1 = never).
  task automatic run_bomb(input logic [9:0] x, input logic [9:0] y,
                          input int frz_at, input int frz_len,
                          input int edge_at, input int bedge_at);
    int guard;
    bus.userX = x;
    bus.userY = y;
    bus.bomb_drop = 1'b1;
    step();
    bus.bomb_drop = 1'b0;
    b_x = bus.bombX;
    b_y = bus.bombY;
    arm_n = 0;
    guard = 0;
    while (bus.bomb_active === 1'b1 && guard < 2000) begin
      arm_n++;
      if (arm_n == frz_at) bus.allow = 5'b00001;
      if (arm_n == frz_at + frz_len) bus.allow = 5'b00010;
      bus.bomb_drop = (arm_n == edge_at);
      step();
      guard++;
    end
    bus.allow   = 5'b00010;
    entry_blast = bus.blast_active;
    entry_bomb  = bus.bomb_active;
    h_x = bus.blastHX;  h_y = bus.blastHY;  h_xs = bus.blastHXS; h_ys = bus.blastHYS;
    v_x = bus.blastVX;  v_y = bus.blastVY;  v_xs = bus.blastVXS; v_ys = bus.blastVYS;
    blast_n = 0;
    guard = 0;
    while (bus.blast_active === 1'b1 && guard < 2000) begin
      blast_n++;
      bus.bomb_drop = (blast_n == bedge_at);
      step();
      guard++;
    end
    bus.bomb_drop = 1'b0;
    post_blast = bus.blast_active;
    post_hx    = bus.blastHX;
    post_vys   = bus.blastVYS;
    post_bx    = bus.bombX;
    step();
    post_active = bus.bomb_active;
    step(2);
  endtask

  initial begin
    int rises;
    logic prev;
    int guard;

    Reset = 1'b1;
    bus.allow = 5'b00000;
    bus.bomb_drop = 1'b0;
    bus.userX = '0;
    bus.userY = '0;
    step(2);
    chk("rst_bomb_active", bus.bomb_active, 0);
    chk("rst_blast_active", bus.blast_active, 0);
    chk("rst_bombX", bus.bombX, 0);
    chk("rst_blastHX", bus.blastHX, 0);
    chk("rst_blastVYS", bus.blastVYS, 0);
    Reset = 1'b0;
    bus.allow = 5'b00010;
    step();

    // Corner drop
    run_bomb(10'd39, 10'd35, -1, 0, -1, -1);
    chk("corner_bombX", b_x, 32);
    chk("corner_bombY", b_y, 32);
    chk("corner_armed_cycles", arm_n, 120);
    chk("corner_blast_entry", entry_blast, 1);
    chk("corner_bomb_drop_at_blast", entry_bomb, 0);
    chk("corner_HX", h_x, 32);
    chk("corner_HY", h_y, 32);
    chk("corner_HXS", h_xs, 96);
    chk("corner_HYS", h_ys, 32);
    chk("corner_VX", v_x, 32);
    chk("corner_VY", v_y, 32);
    chk("corner_VXS", v_xs, 32);
    chk("corner_VYS", v_ys, 96);
    chk("corner_blast_cycles", blast_n, 30);
    chk("corner_post_HX", post_hx, 0);
    chk("corner_post_VYS", post_vys, 0);
    chk("corner_bombX_kept", post_bx, 32);

    // Mid-field with re-drop edges in ARMED (cycle 40) and BLAST (cycle 10)
    run_bomb(10'd300, 10'd200, -1, 0, 40, 10);
    chk("mid_bombX", b_x, 288);
    chk("mid_bombY", b_y, 192);
    chk("mid_armed_cycles", arm_n, REMOTE_ARM);
    chk("mid_HX", h_x, 224);
    chk("mid_HY", h_y, 192);
    chk("mid_HXS", h_xs, 160);
    chk("mid_VX", v_x, 288);
    chk("mid_VY", v_y, 128);
    chk("mid_VYS", v_ys, 160);
    chk("mid_blast_cycles", blast_n, 30);
    chk("mid_no_redrop", post_active, 0);

    // Right/bottom edge clamps
    run_bomb(10'd575, 10'd440, -1, 0, -1, -1);
    chk("right_bombX", b_x, 576);
    chk("right_bombY", b_y, 416);
    chk("right_HX", h_x, 512);
    chk("right_HXS", h_xs, 96);
    chk("right_VY", v_y, 352);
    chk("right_VYS", v_ys, 96);

    // Low-x clamp, y wraps to large value and clamps high
    run_bomb(10'd0, 10'd1000, -1, 0, -1, -1);
    chk("clamp_bombX", b_x, 32);
    chk("clamp_bombY", b_y, 416);

    // Freeze 10 cycles in ARMED; edge on the BLAST->IDLE cycle ignored
    run_bomb(10'd39, 10'd35, 20, 10, -1, 30);
    chk("freeze_armed_cycles", arm_n, 130);
    chk("freeze_blast_cycles", blast_n, 30);
    chk("end_edge_ignored", post_active, 0);
    chk("end_blast_off", post_blast, 0);

    // Edge while frozen in IDLE is lost
    bus.allow = 5'b11111;
    bus.bomb_drop = 1'b1;
    step(2);
    bus.allow = 5'b00010;
    step(2);
    chk("frozen_edge_lost", bus.bomb_active, 0);
    bus.bomb_drop = 1'b0;
    step();

    // Held key for 300 cycles -> exactly one bomb
    rises = 0;
    prev = bus.bomb_active;
    bus.bomb_drop = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.bomb_active === 1'b1 && prev !== 1'b1) rises++;
      prev = bus.bomb_active;
    end
    chk("hold_one_bomb", rises, 1);
    chk("hold_idle_after", bus.bomb_active | bus.blast_active, 0);
    bus.bomb_drop = 1'b0;
    step();

    // Reset mid-BLAST
    bus.userX = 10'd300;
    bus.userY = 10'd200;
    bus.bomb_drop = 1'b1;
    step();
    bus.bomb_drop = 1'b0;
    guard = 0;
    while (bus.blast_active !== 1'b1 && guard < 500) begin
      step();
      guard++;
    end
    chk("rst_mid_reached_blast", bus.blast_active, 1);
    step(3);
    Reset = 1'b1;
    step();
    chk("rst_mid_bomb_active", bus.bomb_active, 0);
    chk("rst_mid_blast_active", bus.blast_active, 0);
    chk("rst_mid_HXS", bus.blastHXS, 0);
    chk("rst_mid_VY", bus.blastVY, 0);
    chk("rst_mid_bombX", bus.bombX, 0);
    Reset = 1'b0;
    step(2);
    chk("rst_mid_stays_idle", bus.bomb_active, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
